bsg_cache_to_dram_ctrl_tx_arb: RTL
==================================

BSG_CACHE_TO_DRAM_CTRL_TX_ARB -- requirements
Module: bsg_cache_to_dram_ctrl_tx_arb

Interface
REQ-001 Parameter num_dma_p, default 4: number of DMA write requesters; SHALL be 2..16.
REQ-002 Parameter dma_data_width_p, default 32: data width per word.
REQ-003 Parameter dma_mask_width_p, default 8: mask width per word.
REQ-004 Parameter burst_len_p, default 8: words per write burst; SHALL be a power of two, at least 2.
REQ-005 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-006 reset_i  input  1  synchronous, active-high reset.
REQ-007 dma_data_v_i  input  num_dma_p  per-requester write-data valid.
REQ-008 dma_data_i  input  num_dma_p*dma_data_width_p  per-requester data; requester i occupies slice i.
REQ-009 dma_mask_i  input  num_dma_p*dma_mask_width_p  per-requester mask; requester i occupies slice i.
REQ-010 dma_data_yumi_o  output  num_dma_p  per-requester word-consumed strobe; at most one bit high.
REQ-011 data_v_o  output  1  arbitrated word valid toward the tx datapath.
REQ-012 data_o  output  dma_data_width_p  arbitrated data.
REQ-013 mask_o  output  dma_mask_width_p  arbitrated mask.
REQ-014 data_yumi_i  input  1  tx datapath consumed the presented word.
REQ-015 grant_v_o  output  1  a burst is owned (BURST state).
REQ-016 grant_id_o  output  clog2(num_dma_p)  current owner index.
REQ-017 burst_last_o  output  1  presented word is the last word of the burst.

Function
REQ-018 States: IDLE and BURST only.
REQ-019 IDLE: when any dma_data_v_i bit is high, the arbiter SHALL register the winner into grant_id and enter BURST on the next edge; no word is transferred in IDLE.
REQ-020 Winner selection: round-robin, scanning from index rr_ptr upward with wrap-around; the first requester with valid high wins.
REQ-021 BURST: data_v_o = dma_data_v_i[grant_id]; data_o and mask_o = slice grant_id of the inputs, driven combinationally.
REQ-022 BURST: dma_data_yumi_o[grant_id] = data_yumi_i; all other yumi bits 0. In IDLE all yumi bits are 0.
REQ-023 Word counter, clog2(burst_len_p) bits, SHALL increment on each data_yumi_i in BURST.
REQ-024 burst_last_o = BURST and counter == burst_len_p-1.
REQ-025 On data_yumi_i with burst_last_o high: counter -> 0, state -> IDLE, rr_ptr -> (grant_id+1) mod num_dma_p.
REQ-026 Grant SHALL stay locked for the whole burst even if the owner drops valid; data_v_o is 0 during such a stall, and other requesters are not served.
REQ-027 Minimum one IDLE cycle between bursts; peak throughput is burst_len_p words per burst_len_p+1 cycles.
REQ-028 data_yumi_i while data_v_o is 0 is illegal: counter and state SHALL not change and no yumi SHALL be issued.
REQ-029 Data and mask pass through with zero latency and no modification.
REQ-030 grant_v_o = (state == BURST); grant_id_o = registered owner, held in IDLE.

Reset
REQ-031 While reset_i is high at a clock edge: state -> IDLE, counter -> 0, rr_ptr -> 0, grant_id -> 0.
REQ-032 Outputs after reset: data_v_o=0, dma_data_yumi_o=0, grant_v_o=0, burst_last_o=0, grant_id_o=0.
REQ-033 Reset asserted mid-burst SHALL abort the burst without issuing a yumi in that cycle; the next grant after reset starts from index 0.

Verification
REQ-034 Single requester 2 holds valid, data_yumi_i held at 1 -> 1 IDLE cycle, then 8 consecutive yumi[2] pulses, burst_last_o on the 8th, grant_v_o falls on the next cycle.
REQ-035 All 4 requesters valid continuously, data_yumi_i=1 -> grant order 0,1,2,3,0, each 8 words, 1 idle cycle between bursts; 36 cycles per round of 4 bursts.
REQ-036 Owner 1 drops valid after 3 words for 5 cycles while requester 3 is valid -> no yumi[3], grant_id_o stays 1, burst resumes at word 4 and ends after word 8.
REQ-037 data_yumi_i=0 for 10 cycles during a burst -> counter frozen, data_v_o=1, no yumi bits issued.
REQ-038 reset_i pulsed at word 5 of owner 3's burst -> IDLE next cycle; with requesters 1 and 3 valid, the next grant goes to 1.
REQ-039 data_yumi_i=1 while no requester is valid -> no state change and all yumi bits 0.

Source files
------------

// File: rtl/bsg_cache_to_dram_ctrl_tx_arb.sv
// bsg_cache_to_dram_ctrl_tx_arb: round-robin burst arbiter from DMA write requesters to one tx datapath
module bsg_cache_to_dram_ctrl_tx_arb #(
  parameter int num_dma_p        = 4,
  parameter int dma_data_width_p = 32,
  parameter int dma_mask_width_p = 8,
  parameter int burst_len_p      = 8,
  localparam int id_w  = $clog2(num_dma_p),
  localparam int cnt_w = $clog2(burst_len_p)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [num_dma_p-1:0]                   dma_data_v_i,
  input  logic [num_dma_p*dma_data_width_p-1:0]  dma_data_i,
  input  logic [num_dma_p*dma_mask_width_p-1:0]  dma_mask_i,
  output logic [num_dma_p-1:0]                   dma_data_yumi_o,
  output logic                                   data_v_o,
  output logic [dma_data_width_p-1:0]            data_o,
  output logic [dma_mask_width_p-1:0]            mask_o,
  input  logic                                   data_yumi_i,
  output logic                                   grant_v_o,
  output logic [id_w-1:0]                        grant_id_o,
  output logic                                   burst_last_o
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;
  logic [0:0]       state_q, state_d;
  logic [cnt_w-1:0] cnt_q, cnt_d;
  logic [id_w-1:0]  rr_q, rr_d, gid_q, gid_d, win, idx;
  logic [id_w:0]    wide;
  logic             burst, xfer;
  always_comb begin
    win  = rr_q;
    idx  = rr_q;
    wide = '0;
    // scan downward so the lowest offset from rr_q is the last (winning) assignment
    for (int i = num_dma_p - 1; i >= 0; i--) begin
      wide = {1'b0, rr_q} + (id_w+1)'(i);
      if (wide >= (id_w+1)'(num_dma_p)) wide = wide - (id_w+1)'(num_dma_p);
      idx = id_w'(wide);
      if (dma_data_v_i[idx]) win = idx;
    end
  end
  assign burst           = state_q == BURST;
  assign data_v_o        = burst & dma_data_v_i[gid_q];
  assign data_o          = dma_data_i[gid_q*dma_data_width_p +: dma_data_width_p];
  assign mask_o          = dma_mask_i[gid_q*dma_mask_width_p +: dma_mask_width_p];
  assign xfer            = data_v_o & data_yumi_i & ~reset_i;
  assign dma_data_yumi_o = xfer ? num_dma_p'(1) << gid_q : '0;
  assign grant_v_o       = burst;
  assign grant_id_o      = gid_q;
  assign burst_last_o    = burst & (cnt_q == cnt_w'(burst_len_p - 1));
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    gid_d   = gid_q;
    if (!burst && |dma_data_v_i) begin
      gid_d   = win;
      state_d = BURST;
    end
    if (xfer) cnt_d = cnt_q + 1'b1;
    if (xfer && burst_last_o) begin
      state_d = IDLE;
      rr_d    = gid_q == id_w'(num_dma_p - 1) ? '0 : gid_q + 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rr_q    <= '0;
      gid_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      gid_q   <= gid_d;
    end
  end
endmodule
